// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared definitions for the boot-image loader.
//   state_e            : loader FSM states
//   SYNC_BYTE_DEFAULT  : default start-of-image marker
//   INSTR_W            : instruction word width (matches core ir)
`timescale 1ns/1ps
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         INSTR_W           = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WR,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader -- receives a byte-stream program image and writes it into the
// core instruction memory, then releases the core.
//
// Image format: SYNC_BYTE, length N (0 = 256 words), N x {hi, lo} bytes,
// optionally followed by an XOR checksum byte.
//
// Build option: define PROG_LOADER_CHECKSUM_EN to require and verify the
// trailing checksum byte (mismatch raises load_err). Without it the image
// ends after the last word and load_err is tied low.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   rx_data, rx_valid   incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready at clk rise
//   mem_we              one-cycle write strobe to instruction memory
//   mem_addr, mem_wdata write address / instruction word
//   core_run            high once a good image is loaded (low holds core pc)
//   load_err            last image rejected by checksum
`timescale 1ns/1ps
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_run,
  output logic               load_err
);

  // Length byte 0 means 256 words, but never more than the memory holds.
  localparam logic [8:0] FULL_LEN = (ADDR_W >= 8) ? 9'd256 : 9'(1 << ADDR_W);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [8:0]           remain_q, remain_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif
  logic                 fire;

  assign rx_ready  = (state_q != WR);
  assign fire      = rx_valid && rx_ready;
  assign mem_we    = (state_q == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_run  = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign load_err  = (state_q == ERR);
`else
  assign load_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      remain_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      remain_q <= remain_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    remain_d = remain_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      // Outside an image only the marker matters; everything else is dropped.
      IDLE, DONE, ERR: begin
        if (fire && (rx_data == SYNC_BYTE)) begin
          state_d = LEN;
          addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN: begin
        if (fire) begin
          remain_d = (rx_data == 8'd0) ? FULL_LEN : {1'b0, rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d   = rx_data;
`endif
          state_d  = HI;
        end
      end
      HI: begin
        if (fire) begin
          wdata_d[15:8] = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d        = csum_q ^ rx_data;
`endif
          state_d       = LO;
        end
      end
      LO: begin
        if (fire) begin
          wdata_d[7:0] = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ rx_data;
`endif
          state_d      = WR;
        end
      end
      // Single write cycle; input is stalled so address/data stay stable.
      WR: begin
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - 9'd1;
        if (remain_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- self-checking bench for prog_loader.
// A byte-stream parser model predicts every memory write and the final
// core_run/load_err status; a compare process checks each write strobe.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam logic [7:0] SYNC = 8'hA5;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        core_run;
   logic        load_err;

   int   testsRun = 0;
   int   testsFailed = 0;
   wr_t  expW[$];
   wr_t  obsLog[$];
   logic mRun = 1'b0;
   logic mErr = 1'b0;
   logic prevWe = 1'b0;

   prog_loader #(.SYNC_BYTE(SYNC), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_run  (core_run),
      .load_err  (load_err)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case the bench itself gets stuck
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time got 900000, expected completion earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference parser: scan for the marker, read length and word pairs,
   // optionally the checksum; predicts writes and final status
   task automatic runModel(input logic [7:0] q[$]);
      int         i;
      int         words;
      logic [7:0] cs, len, hi, lo, a;
      i = 0;
      while (i < q.size()) begin
         if (q[i] != SYNC) begin
            i++;
            continue;
         end
         i++;
         mRun = 1'b0;
         mErr = 1'b0;
         len = q[i];
         i++;
         cs = len;
         words = (len == 8'd0) ? 256 : int'(len);
         a = 8'd0;
         for (int w = 0; w < words; w++) begin
            hi = q[i];
            lo = q[i + 1];
            i += 2;
            cs = cs ^ hi ^ lo;
            expW.push_back('{a, {hi, lo}});
            a++;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         if (q[i] == cs) mRun = 1'b1;
         else            mErr = 1'b1;
         i++;
`else
         mRun = 1'b1;
`endif
      end
   endtask

   // Builds a complete image with random data (marker value over-represented)
   task automatic makeImage(input int lenByte, input bit badChk, output logic [7:0] img[$]);
      logic [7:0] cs, b;
      int         words;
      img = {};
      img.push_back(SYNC);
      b = 8'(lenByte);
      img.push_back(b);
      cs = b;
      words = (b == 8'd0) ? 256 : int'(b);
      for (int k = 0; k < 2 * words; k++) begin
         b = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
         img.push_back(b);
         cs = cs ^ b;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      img.push_back(badChk ? ~cs : cs);
`else
      if (badChk) img.push_back(8'h3C);
`endif
   endtask

   // Drives one byte and returns right after the accepting clock edge
   task automatic sendByte(input logic [7:0] b);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!rx_ready) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL handshake_timeout: rx_ready got 0, expected 1");
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] q[$], input bit gapsOn);
      runModel(q);
      foreach (q[k]) begin
         sendByte(q[k]);
         if (gapsOn && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end
      end
   endtask

   task automatic endCheck(input string tag);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput({tag, "_core_run"}, 32'(core_run), 32'(mRun));
      checkOutput({tag, "_load_err"}, 32'(load_err), 32'(mErr));
      checkOutput({tag, "_pending_writes"}, 32'(expW.size()), 32'd0);
   endtask

   // Hand-computed writes of the reference image A5 02 40 05 78 00 3F
   task automatic checkLiteralWrites(input string tag);
      checkOutput({tag, "_lit_count"}, 32'(obsLog.size()), 32'd2);
      if (obsLog.size() == 2) begin
         checkOutput({tag, "_lit_a0"}, 32'(obsLog[0].addr), 32'h00);
         checkOutput({tag, "_lit_d0"}, 32'(obsLog[0].data), 32'h4005);
         checkOutput({tag, "_lit_a1"}, 32'(obsLog[1].addr), 32'h01);
         checkOutput({tag, "_lit_d1"}, 32'(obsLog[1].data), 32'h7800);
      end
   endtask

   // Every cycle out of reset: ready/strobe exclusivity and write scoreboard
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         checkOutput("ready_vs_we", 32'(rx_ready), 32'(!mem_we));
         if (mem_we) begin
            checkOutput("we_single_cycle", 32'(prevWe), 32'd0);
            if (expW.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
               e = expW.pop_front();
               checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
               checkOutput("wr_data", 32'(mem_wdata), 32'(e.data));
            end
            obsLog.push_back('{mem_addr, mem_wdata});
         end
         prevWe = mem_we;
      end else begin
         prevWe = 1'b0;
      end
   end

   // Test sequence
   initial begin
      logic [7:0] img[$];
      logic [7:0] tmp[$];
      logic [7:0] goodImg[$];
      logic [7:0] badImg[$];

      goodImg = '{8'hA5, 8'h02, 8'h40, 8'h05, 8'h78, 8'h00, 8'h3F};
      badImg  = '{8'hA5, 8'h02, 8'h40, 8'h05, 8'h78, 8'h00, 8'h3E};

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("rst_core_run", 32'(core_run), 32'd0);
      checkOutput("rst_load_err", 32'(load_err), 32'd0);
      rst_n = 1'b1;

      // Reference image
      obsLog.delete();
      applyStimulus(goodImg, 1'b1);
      endCheck("ref_image");
      checkLiteralWrites("ref_image");
      checkOutput("ref_lit_core_run", 32'(core_run), 32'd1);
      checkOutput("ref_lit_load_err", 32'(load_err), 32'd0);

      // Wrong checksum, then a good image
      applyStimulus(badImg, 1'b1);
      endCheck("bad_chk");
`ifdef PROG_LOADER_CHECKSUM_EN
      checkOutput("bad_chk_lit_load_err", 32'(load_err), 32'd1);
      checkOutput("bad_chk_lit_core_run", 32'(core_run), 32'd0);
`else
      checkOutput("bad_chk_lit_core_run", 32'(core_run), 32'd1);
`endif
      applyStimulus(goodImg, 1'b1);
      endCheck("recover");
      checkOutput("recover_lit_load_err", 32'(load_err), 32'd0);
      checkOutput("recover_lit_core_run", 32'(core_run), 32'd1);

      // Leading garbage before the image
      obsLog.delete();
      img = '{8'h11, 8'h22};
      foreach (goodImg[k]) img.push_back(goodImg[k]);
      applyStimulus(img, 1'b1);
      endCheck("garbage");
      checkLiteralWrites("garbage");

      // Back-to-back images with rx_valid held high
      img = {};
      for (int n = 0; n < 4; n++) begin
         makeImage($urandom_range(1, 12), 1'b0, tmp);
         foreach (tmp[k]) img.push_back(tmp[k]);
      end
      applyStimulus(img, 1'b0);
      endCheck("continuous");

      // Reset in the middle of an image
      sendByte(SYNC);
      sendByte(8'h02);
      sendByte(8'h40);
      #1;
      rx_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rx_ready", 32'(rx_ready), 32'd1);
      checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("midrst_core_run", 32'(core_run), 32'd0);
      checkOutput("midrst_load_err", 32'(load_err), 32'd0);
      expW.delete();
      mRun = 1'b0;
      mErr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      obsLog.delete();
      applyStimulus(goodImg, 1'b1);
      endCheck("after_rst");
      checkLiteralWrites("after_rst");

      // Length byte 0: full 256-word image
      obsLog.delete();
      makeImage(0, 1'b0, img);
      applyStimulus(img, 1'b0);
      endCheck("len0");
      checkOutput("len0_lit_count", 32'(obsLog.size()), 32'd256);
      if (obsLog.size() == 256) begin
         checkOutput("len0_lit_last_addr", 32'(obsLog[255].addr), 32'hFF);
      end

      // Random images with garbage and occasional bad checksums
      for (int n = 0; n < 20; n++) begin
         img = {};
         repeat ($urandom_range(0, 3)) img.push_back(8'($urandom_range(0, 8'hA4)));
         makeImage($urandom_range(1, 20), ($urandom_range(0, 3) == 0), tmp);
         foreach (tmp[k]) img.push_back(tmp[k]);
         applyStimulus(img, 1'b1);
         endCheck("random");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, start-of-image marker.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-003 SHALL have one clock and async active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_data input 8, incoming byte stream.
REQ-005 SHALL have port rx_valid input 1, rx_data valid.
REQ-006 SHALL have port rx_ready output 1, loader accepts byte; transfer occurs when rx_valid && rx_ready at clk rise.
REQ-007 SHALL have port mem_we output 1, one-cycle write strobe to core instruction memory.
REQ-008 SHALL have port mem_addr output ADDR_W, write address.
REQ-009 SHALL have port mem_wdata output 16, instruction word, bit layout identical to core ir.
REQ-010 SHALL have port core_run output 1, releases core; low holds core pc at 0.
REQ-011 SHALL have port load_err output 1, last image rejected.

Function
REQ-012 SHALL implement states IDLE, LEN, HI, LO, WR, CHK, DONE, ERR.
REQ-013 IDLE: bytes other than SYNC_BYTE are consumed and discarded; SYNC_BYTE -> LEN, core_run<=0, load_err<=0, word address<=0.
REQ-014 LEN: byte N captured as word count; N=0 means 256 words (truncated to 2**ADDR_W); -> HI.
REQ-015 HI: byte captured as mem_wdata[15:8] (MSB first); -> LO.
REQ-016 LO: byte captured as mem_wdata[7:0]; -> WR.
REQ-017 WR: rx_ready=0, mem_we=1 for exactly one cycle with current mem_addr; then address+1; -> HI if words remain, else CHK (or DONE per REQ-025).
REQ-018 rx_ready SHALL be 1 in every state except WR.
REQ-019 Checksum: running XOR of length byte and all data bytes; CHK byte equal to it -> DONE, else -> ERR.
REQ-020 DONE: core_run=1 continuously; SYNC_BYTE received -> LEN with core_run low from next cycle; other bytes discarded.
REQ-021 ERR: load_err=1, core_run=0; SYNC_BYTE -> LEN; other bytes discarded.
REQ-022 Data bytes equal to SYNC_BYTE inside an image SHALL be treated as data, not resync.
REQ-023 mem_addr/mem_wdata SHALL be stable during mem_we; memory already written by a rejected image is not restored.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, load_err=0, checksum=0, including mid-image.

Configuration
REQ-025 Macro PROG_LOADER_CHECKSUM_EN defined: CHK state and checksum byte present per REQ-019; undefined: no checksum byte, last WR -> DONE directly, load_err tied 0, ERR unreachable.

Structure
REQ-026 Package prog_loader_pkg SHALL hold state enumeration, SYNC_BYTE default and instruction-word width (16).
REQ-027 No sub-module; single FSM with datapath registers.

Verification
REQ-028 Bytes A5,02,40,05,78,00,3F -> writes addr0=16'h4005, addr1=16'h7800, core_run=1, load_err=0.
REQ-029 Same image with checksum 3E -> load_err=1, core_run=0; then full valid image -> load_err=0, core_run=1.
REQ-030 Bytes 11,22 then valid image of REQ-028 -> 11,22 ignored, identical writes.
REQ-031 rx_valid held high continuously -> rx_ready=0 in each WR cycle, no byte lost or duplicated; mem_we exactly one cycle per word.
REQ-032 rst_n pulsed low after HI byte -> all outputs reset values same cycle; subsequent REQ-028 image writes from addr0.
REQ-033 Length 00 with 512 data bytes -> 256 writes addr 0..255, then checksum check, core_run=1.
